spi_txn_ctrl: RTL and testbench

Transaction sequencer for the byte-level SPI host engine. It accepts a multi-byte command and manages chip select, including setup, hold and idle gaps. It feeds TX bytes to the engine one at a time, starting each byte with a start/done handshake, and returns each received byte as a one-cycle pulse. It sits between the SPI peripheral register/bus logic and the SPI host engine.

---
 rtl/spi_txn_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_txn_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_ctrl.sv
// rtl/spi_txn_ctrl.sv - chip-select timing and byte sequencing for the SPI host engine
// Accepts a multi-byte command, frames it with CS setup/hold/idle gaps and hands bytes to the engine.

module spi_txn_ctrl #(
  parameter int unsigned CsSetupCycles = 4,
  parameter int unsigned CsHoldCycles  = 4,
  parameter int unsigned CsIdleCycles  = 4,
  parameter int unsigned LenWidth      = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [LenWidth-1:0] cmd_len_i,
  input  logic                tx_valid_i,
  input  logic [7:0]          tx_data_i,
  output logic                tx_ready_o,
  output logic                rx_valid_o,
  output logic [7:0]          rx_data_o,
  output logic                busy_o,
  output logic                cs_no,
  output logic                eng_start_o,
  output logic [7:0]          eng_tx_byte_o,
  input  logic [7:0]          eng_rx_byte_i,
  input  logic                eng_done_i
);

  localparam int unsigned MaxSh  = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
  localparam int unsigned MaxDly = (MaxSh > CsIdleCycles) ? MaxSh : CsIdleCycles;
  localparam int unsigned CntW   = $clog2(MaxDly) + 1;

  localparam logic [CntW-1:0] SetupLoad = CntW'(CsSetupCycles - 1);
  localparam logic [CntW-1:0] HoldLoad  = CntW'(CsHoldCycles - 1);
  localparam logic [CntW-1:0] IdleLoad  = CntW'(CsIdleCycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_WAIT_TX,
    ST_XFER,
    ST_CS_HOLD,
    ST_CS_IDLE
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     dly_q;
  logic [LenWidth-1:0] byte_cnt_q;
  logic                done_q;
  logic                cmd_ready_q;
  logic                rx_valid_q;
  logic [7:0]          rx_data_q;
  logic                busy_q;
  logic                cs_n_q;
  logic                eng_start_q;
  logic [7:0]          eng_tx_byte_q;

  logic done_rise;
  logic tx_ready;

  assign done_rise = eng_done_i & ~done_q;

  // The final setup cycle already offers the TX handshake, so the first start
  // lands exactly CsSetupCycles after cs_no falls when data is waiting.
  assign tx_ready = (state_q == ST_WAIT_TX) ||
                    ((state_q == ST_CS_SETUP) && (dly_q == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      dly_q         <= '0;
      byte_cnt_q    <= '0;
      done_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      eng_start_q   <= 1'b0;
      eng_tx_byte_q <= 8'h00;
    end else begin
      done_q     <= eng_done_i;
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            byte_cnt_q  <= cmd_len_i;
            dly_q       <= SetupLoad;
            cs_n_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (tx_valid_i && tx_ready) begin
            eng_tx_byte_q <= tx_data_i;
            eng_start_q   <= 1'b1;
            state_q       <= ST_XFER;
          end else if (dly_q == '0) begin
            state_q <= ST_WAIT_TX;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        ST_WAIT_TX: begin
          if (tx_valid_i) begin
            eng_tx_byte_q <= tx_data_i;
            eng_start_q   <= 1'b1;
            state_q       <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (done_rise) begin
            eng_start_q <= 1'b0;
            rx_valid_q  <= 1'b1;
            rx_data_q   <= eng_rx_byte_i;
            if (byte_cnt_q == '0) begin
              dly_q   <= HoldLoad;
              state_q <= ST_CS_HOLD;
            end else begin
              byte_cnt_q <= byte_cnt_q - 1'b1;
              state_q    <= ST_WAIT_TX;
            end
          end
        end
        ST_CS_HOLD: begin
          if (dly_q == '0) begin
            cs_n_q  <= 1'b1;
            dly_q   <= IdleLoad;
            state_q <= ST_CS_IDLE;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        ST_CS_IDLE: begin
          if (dly_q == '0) begin
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        default: begin
          cs_n_q      <= 1'b1;
          eng_start_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign tx_ready_o    = tx_ready;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign busy_o        = busy_q;
  assign cs_no         = cs_n_q;
  assign eng_start_o   = eng_start_q;
  assign eng_tx_byte_o = eng_tx_byte_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb/tb_spi_txn_ctrl.sv - directed self-checking bench for spi_txn_ctrl
// Engine model returns each TX byte XOR 0x99 after a programmable latency.

module tb_spi_txn_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [7:0] cmd_len_i = 8'h00;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       busy_o;
  logic       cs_no;
  logic       eng_start_o;
  logic [7:0] eng_tx_byte_o;
  logic [7:0] eng_rx_byte_i;
  logic       eng_done_i;

  spi_txn_ctrl #(
    .CsSetupCycles(4),
    .CsHoldCycles (4),
    .CsIdleCycles (4),
    .LenWidth     (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_len_i    (cmd_len_i),
    .tx_valid_i   (tx_valid_i),
    .tx_data_i    (tx_data_i),
    .tx_ready_o   (tx_ready_o),
    .rx_valid_o   (rx_valid_o),
    .rx_data_o    (rx_data_o),
    .busy_o       (busy_o),
    .cs_no        (cs_no),
    .eng_start_o  (eng_start_o),
    .eng_tx_byte_o(eng_tx_byte_o),
    .eng_rx_byte_i(eng_rx_byte_i),
    .eng_done_i   (eng_done_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  int eng_lat  = 3;
  int done_len = 1;

  logic [7:0] tx_q[$];
  logic       tx_en = 1'b0;
  int         tx_gen = 0;
  int         tx_hs_cyc = 0;

  int clr_req = 0;
  logic [7:0] tx_log[$];
  logic [7:0] rx_log[$];
  int t_start[$];
  int t_sfall[$];
  int t_rx[$];
  int t_csfall[$];
  int t_csrise[$];
  int t_rdy[$];

  // engine model
  initial begin
    logic [7:0] b;
    eng_done_i    = 1'b0;
    eng_rx_byte_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_ni && eng_start_o) begin
        b = eng_tx_byte_o;
        repeat (eng_lat) @(negedge clk_i);
        eng_rx_byte_i = b ^ 8'h99;
        eng_done_i    = 1'b1;
        repeat (done_len) @(negedge clk_i);
        eng_done_i = 1'b0;
      end
    end
  end

  // TX byte source
  initial begin
    int idx;
    int gen_seen;
    idx = 0;
    gen_seen = 0;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (tx_gen != gen_seen) begin
        gen_seen = tx_gen;
        idx = 0;
      end
      if (tx_en && idx < tx_q.size()) begin
        tx_valid_i = 1'b1;
        tx_data_i  = tx_q[idx];
      end else begin
        tx_valid_i = 1'b0;
      end
      if (tx_valid_i && tx_ready_o && rst_ni) begin
        tx_hs_cyc = cyc;
        @(posedge clk_i);
        idx++;
      end
    end
  end

  // event monitor
  initial begin
    int   seen;
    logic cs_prev, st_prev, rdy_prev;
    seen = 0;
    cs_prev = 1'b1;
    st_prev = 1'b0;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (clr_req != seen) begin
        seen = clr_req;
        tx_log.delete(); rx_log.delete();
        t_start.delete(); t_sfall.delete(); t_rx.delete();
        t_csfall.delete(); t_csrise.delete(); t_rdy.delete();
      end
      if (eng_start_o && !st_prev) begin
        t_start.push_back(cyc);
        tx_log.push_back(eng_tx_byte_o);
      end
      if (!eng_start_o && st_prev) t_sfall.push_back(cyc);
      if (rx_valid_o) begin
        t_rx.push_back(cyc);
        rx_log.push_back(rx_data_o);
      end
      if (!cs_no && cs_prev) t_csfall.push_back(cyc);
      if (cs_no && !cs_prev) t_csrise.push_back(cyc);
      if (cmd_ready_o && !rdy_prev) t_rdy.push_back(cyc);
      cs_prev  = cs_no;
      st_prev  = eng_start_o;
      rdy_prev = cmd_ready_o;
    end
  end

  task automatic clear_logs();
    clr_req++;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic load_tx(input logic [7:0] bytes[$]);
    tx_en = 1'b0;
    @(negedge clk_i);
    tx_q = bytes;
    tx_gen++;
    @(negedge clk_i);
  endtask

  task automatic run_cmd(input logic [7:0] len);
    int k;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_len_i   = len;
    k = 0;
    while (!cmd_ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    checks++;
    if (k >= 100) $display("FAIL cmd_accept: cmd_ready_o never rose within %0d cycles", k);
    else passes++;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (!(cmd_ready_o && !busy_o) && k < bound) begin
      @(negedge clk_i);
      k++;
    end
    checks++;
    if (k >= bound) $display("FAIL wait_idle: still busy after %0d cycles", k);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if ({cmd_ready_o, tx_ready_o, rx_valid_o, busy_o, cs_no, eng_start_o} !== 6'b000010)
      $display("FAIL reset_ctrl: got %b required 000010",
               {cmd_ready_o, tx_ready_o, rx_valid_o, busy_o, cs_no, eng_start_o});
    else passes++;
    checks++;
    if ({rx_data_o, eng_tx_byte_o} !== 16'h0000)
      $display("FAIL reset_data: got %h required 0000", {rx_data_o, eng_tx_byte_o});
    else passes++;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({cmd_ready_o, busy_o, cs_no} !== 3'b101)
      $display("FAIL reset_release: got %b required 101", {cmd_ready_o, busy_o, cs_no});
    else passes++;
  endtask

  task automatic test_single();
    eng_lat = 3; done_len = 1;
    load_tx('{8'hA5});
    clear_logs();
    tx_en = 1'b1;
    run_cmd(8'd0);
    wait_idle(200);
    checks++;
    if (t_start.size() !== 1 || tx_log[0] !== 8'hA5)
      $display("FAIL single_tx: starts %0d byte %h required 1 a5", t_start.size(), tx_log[0]);
    else passes++;
    checks++;
    if (rx_log.size() !== 1 || rx_log[0] !== 8'h3C)
      $display("FAIL single_rx: pulses %0d byte %h required 1 3c", rx_log.size(), rx_log[0]);
    else passes++;
    checks++;
    if (t_start[0] - t_csfall[0] !== 4)
      $display("FAIL single_setup: got %0d cycles required 4", t_start[0] - t_csfall[0]);
    else passes++;
    checks++;
    if (t_csrise[0] - t_rx[0] !== 4)
      $display("FAIL single_hold: got %0d cycles required 4", t_csrise[0] - t_rx[0]);
    else passes++;
    checks++;
    if (t_rdy[0] - t_csrise[0] !== 4)
      $display("FAIL single_idle: got %0d cycles required 4", t_rdy[0] - t_csrise[0]);
    else passes++;
    repeat (3) @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'h3C) $display("FAIL single_rx_hold: got %h required 3c", rx_data_o);
    else passes++;
  endtask

  task automatic test_burst();
    eng_lat = 2; done_len = 1;
    load_tx('{8'h01, 8'h02, 8'h03, 8'h04});
    clear_logs();
    tx_en = 1'b1;
    run_cmd(8'd3);
    wait_idle(300);
    checks++;
    if (t_start.size() !== 4 || {tx_log[0], tx_log[1], tx_log[2], tx_log[3]} !== 32'h01020304)
      $display("FAIL burst_tx: starts %0d bytes %h required 4 01020304", t_start.size(),
               {tx_log[0], tx_log[1], tx_log[2], tx_log[3]});
    else passes++;
    checks++;
    if (rx_log.size() !== 4 || {rx_log[0], rx_log[1], rx_log[2], rx_log[3]} !== 32'h989B9A9D)
      $display("FAIL burst_rx: pulses %0d bytes %h required 4 989b9a9d", rx_log.size(),
               {rx_log[0], rx_log[1], rx_log[2], rx_log[3]});
    else passes++;
    checks++;
    if (t_csfall.size() !== 1 || t_csrise.size() !== 1)
      $display("FAIL burst_cs: falls %0d rises %0d required 1 1", t_csfall.size(), t_csrise.size());
    else passes++;
  endtask

  task automatic test_underflow();
    int k;
    int bad;
    eng_lat = 3; done_len = 1;
    load_tx('{8'h5A});
    clear_logs();
    run_cmd(8'd0);
    k = 0;
    while (!tx_ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (cs_no !== 1'b0 || eng_start_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || k >= 50) $display("FAIL underflow_stall: %0d bad cycles (wait %0d) required 0", bad, k);
    else passes++;
    tx_en = 1'b1;
    wait_idle(200);
    checks++;
    if (t_start.size() !== 1 || t_start[0] - tx_hs_cyc !== 1)
      $display("FAIL underflow_resume: starts %0d delay %0d required 1 1", t_start.size(),
               t_start[0] - tx_hs_cyc);
    else passes++;
    checks++;
    if (rx_log.size() !== 1 || rx_log[0] !== 8'hC3)
      $display("FAIL underflow_rx: pulses %0d byte %h required 1 c3", rx_log.size(), rx_log[0]);
    else passes++;
  endtask

  task automatic test_long_done();
    eng_lat = 2; done_len = 8;
    load_tx('{8'hC0, 8'hC1});
    clear_logs();
    tx_en = 1'b1;
    run_cmd(8'd1);
    wait_idle(300);
    checks++;
    if (t_start.size() !== 2 || rx_log.size() !== 2)
      $display("FAIL long_done_count: starts %0d pulses %0d required 2 2", t_start.size(), rx_log.size());
    else passes++;
    checks++;
    if ({rx_log[0], rx_log[1]} !== 16'h5958)
      $display("FAIL long_done_rx: got %h required 5958", {rx_log[0], rx_log[1]});
    else passes++;
    checks++;
    if (t_sfall[0] !== t_rx[0])
      $display("FAIL long_done_start_drop: fell at %0d rx at %0d", t_sfall[0], t_rx[0]);
    else passes++;
    done_len = 1;
  endtask

  task automatic test_back_to_back();
    int k;
    int bad;
    eng_lat = 3; done_len = 1;
    load_tx('{8'h11, 8'h22});
    clear_logs();
    tx_en = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_len_i   = 8'd0;
    k = 0;
    bad = 0;
    while (t_csfall.size() < 2 && k < 200) begin
      @(negedge clk_i);
      if (cs_no && busy_o && cmd_ready_o) bad++;
      k++;
    end
    cmd_valid_i = 1'b0;
    wait_idle(200);
    checks++;
    if (k >= 200 || t_csfall.size() !== 2)
      $display("FAIL b2b_second: cs falls %0d required 2", t_csfall.size());
    else passes++;
    checks++;
    if (t_csfall[1] - t_csrise[0] < 4)
      $display("FAIL b2b_gap: got %0d cycles required >= 4", t_csfall[1] - t_csrise[0]);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL b2b_ready_in_idle: %0d cycles ready required 0", bad);
    else passes++;
    checks++;
    if (t_csrise[1] - t_csfall[1] !== t_csrise[0] - t_csfall[0] || t_csrise[0] - t_csfall[0] !== 12)
      $display("FAIL b2b_frame: got %0d and %0d cycles required 12", t_csrise[0] - t_csfall[0],
               t_csrise[1] - t_csfall[1]);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int k;
    eng_lat = 6; done_len = 1;
    load_tx('{8'h31, 8'h32, 8'h33, 8'h34});
    clear_logs();
    tx_en = 1'b1;
    run_cmd(8'd3);
    k = 0;
    while (t_start.size() < 2 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    tx_en = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (k >= 200 || cs_no !== 1'b1 || eng_start_o !== 1'b0)
      $display("FAIL reset_mid_async: cs_no %b start %b required 1 0", cs_no, eng_start_o);
    else passes++;
    @(negedge clk_i);
    checks++;
    if ({busy_o, rx_valid_o, rx_data_o, eng_tx_byte_o} !== 18'h0)
      $display("FAIL reset_mid_clear: got %h required 0", {busy_o, rx_valid_o, rx_data_o, eng_tx_byte_o});
    else passes++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (15) @(negedge clk_i);
    checks++;
    if ({busy_o, cs_no} !== 2'b01) $display("FAIL reset_mid_idle: got %b required 01", {busy_o, cs_no});
    else passes++;
    load_tx('{8'h77});
    clear_logs();
    tx_en = 1'b1;
    run_cmd(8'd0);
    wait_idle(200);
    checks++;
    if (rx_log.size() !== 1 || rx_log[0] !== 8'hEE || t_start.size() !== 1)
      $display("FAIL reset_mid_recover: pulses %0d byte %h starts %0d required 1 ee 1",
               rx_log.size(), rx_log[0], t_start.size());
    else passes++;
  endtask

  task automatic test_max_len();
    logic [7:0] bytes[$];
    for (int i = 0; i < 256; i++) bytes.push_back(8'(i));
    eng_lat = 1; done_len = 1;
    load_tx(bytes);
    clear_logs();
    tx_en = 1'b1;
    run_cmd(8'hFF);
    wait_idle(5000);
    checks++;
    if (t_start.size() !== 256 || rx_log.size() !== 256)
      $display("FAIL max_len_count: starts %0d pulses %0d required 256 256", t_start.size(), rx_log.size());
    else passes++;
    checks++;
    if (rx_log[255] !== 8'h66 || rx_log[0] !== 8'h99)
      $display("FAIL max_len_rx: first %h last %h required 99 66", rx_log[0], rx_log[255]);
    else passes++;
    checks++;
    if (t_csfall.size() !== 1 || t_csrise.size() !== 1)
      $display("FAIL max_len_cs: falls %0d rises %0d required 1 1", t_csfall.size(), t_csrise.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_underflow();
    test_long_done();
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
